// File: rtl/dm_pkg.sv
// Shared types and constants for the data-memory responder.
package dm_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dm_state_e;

  localparam int unsigned LANE_W    = 8;
  localparam int unsigned NUM_LANES = 4;

endpackage

// File: rtl/dm_if.sv
// Load/store request/response handshake between the M stage (master) and the responder (slave).
interface dm_if import dm_pkg::*; ();

  logic                        req_valid;
  logic                        req_ready;
  logic                        req_we;
  logic [31:0]                 req_addr;
  logic [NUM_LANES-1:0]        req_be;
  logic [NUM_LANES*LANE_W-1:0] req_wdata;
  logic [31:0]                 req_pc4;
  logic                        rsp_valid;
  logic [NUM_LANES*LANE_W-1:0] rsp_rdata;
  logic                        rsp_err;
  logic                        busy;

  modport master (
    output req_valid, req_we, req_addr, req_be, req_wdata, req_pc4,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_be, req_wdata, req_pc4,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, busy
  );

endinterface

// File: rtl/dm_be_merge.sv
// Byte-lane merge: enabled lanes take wdata, the rest keep the old word.
module dm_be_merge import dm_pkg::*; (
  input  logic [NUM_LANES*LANE_W-1:0] old_word,
  input  logic [NUM_LANES*LANE_W-1:0] wdata,
  input  logic [NUM_LANES-1:0]        be,
  output logic [NUM_LANES*LANE_W-1:0] merged
);

  always_comb begin
    merged = old_word;
    for (int i = 0; i < int'(NUM_LANES); i++) begin
      if (be[i]) merged[i*LANE_W +: LANE_W] = wdata[i*LANE_W +: LANE_W];
    end
  end

endmodule

// File: rtl/dm_responder.sv
// Data-memory responder with WAIT_CYCLES wait states and a one-cycle response pulse.
// Optional write trace enabled by defining DM_TRACE_EN.
module dm_responder import dm_pkg::*; #(
  parameter int unsigned DEPTH_WORDS = 4096,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input logic clk,
  input logic reset,
  dm_if.slave bus
);

  localparam int unsigned IDX_W    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [7:0]  CNT_LOAD = (WAIT_CYCLES == 0) ? 8'd0 : 8'(WAIT_CYCLES - 1);

  dm_state_e   state_q;
  logic [7:0]  cnt_q;
  logic        lat_we;
  logic [31:0] lat_addr;
  logic [3:0]  lat_be;
  logic [31:0] lat_wdata;
  logic        rsp_valid_q;
  logic [31:0] rsp_rdata_q;
  logic        rsp_err_q;

  logic [31:0] mem [DEPTH_WORDS];

  logic             cur_we;
  logic [31:0]      cur_addr;
  logic [3:0]       cur_be;
  logic [31:0]      cur_wdata;
  logic             cur_err;
  logic             enter_resp;
  logic             commit_wr;
  logic [IDX_W-1:0] idx;
  logic [31:0]      old_word;
  logic [31:0]      merged;

  // With zero wait states the request commits on its own acceptance edge, so use the live inputs.
  always_comb begin
    cur_we    = (state_q == IDLE) ? bus.req_we    : lat_we;
    cur_addr  = (state_q == IDLE) ? bus.req_addr  : lat_addr;
    cur_be    = (state_q == IDLE) ? bus.req_be    : lat_be;
    cur_wdata = (state_q == IDLE) ? bus.req_wdata : lat_wdata;
    cur_err   = (cur_addr[1:0] != 2'b00) || ({2'b00, cur_addr[31:2]} >= DEPTH_WORDS) ||
                (cur_we && (cur_be == 4'b0000));
    enter_resp = ((state_q == IDLE) && bus.req_valid && (WAIT_CYCLES == 0)) ||
                 ((state_q == WAIT) && (cnt_q == 8'd0));
    commit_wr  = enter_resp && cur_we && !cur_err;
    idx        = cur_addr[IDX_W+1:2];
    old_word   = mem[idx];
  end

  dm_be_merge u_merge (
    .old_word (old_word),
    .wdata    (cur_wdata),
    .be       (cur_be),
    .merged   (merged)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= 8'd0;
      lat_we      <= 1'b0;
      lat_addr    <= 32'd0;
      lat_be      <= 4'd0;
      lat_wdata   <= 32'd0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'd0;
      rsp_err_q   <= 1'b0;
    end else begin
      rsp_valid_q <= enter_resp;
      if (enter_resp) begin
        rsp_err_q   <= cur_err;
        rsp_rdata_q <= (cur_err || cur_we) ? 32'd0 : old_word;
      end
      case (state_q)
        IDLE: begin
          if (bus.req_valid) begin
            lat_we    <= bus.req_we;
            lat_addr  <= bus.req_addr;
            lat_be    <= bus.req_be;
            lat_wdata <= bus.req_wdata;
            cnt_q     <= CNT_LOAD;
            state_q   <= (WAIT_CYCLES == 0) ? RESP : WAIT;
          end
        end
        WAIT: begin
          if (cnt_q == 8'd0) state_q <= RESP;
          else               cnt_q   <= cnt_q - 8'd1;
        end
        RESP:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH_WORDS); i++) mem[i] <= 32'd0;
    end else if (commit_wr) begin
      mem[idx] <= merged;
    end
  end

`ifdef DM_TRACE_EN
  logic [31:0] lat_pc4;
  logic [31:0] cur_pc4;

  assign cur_pc4 = (state_q == IDLE) ? bus.req_pc4 : lat_pc4;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                        lat_pc4 <= 32'd0;
    else if ((state_q == IDLE) && bus.req_valid)      lat_pc4 <= bus.req_pc4;
  end

  always_ff @(posedge clk) begin
    if (!reset && commit_wr) begin
      $display("@%h: *%h <= %h", cur_pc4 - 32'd4, {cur_addr[31:2], 2'b00}, merged);
    end
  end
`else
  logic unused_pc4;
  assign unused_pc4 = ^bus.req_pc4;
`endif

  assign bus.req_ready = (state_q == IDLE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_dm_responder.sv
// Bench for dm_responder: a WAIT_CYCLES=2 and a WAIT_CYCLES=0 instance against a word-array model.
module tb_dm_responder;
  import dm_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  dm_if bus2 ();
  dm_if bus0 ();

  dm_responder #(.DEPTH_WORDS(4096), .WAIT_CYCLES(2)) dut2 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus2.slave)
  );

  dm_responder #(.DEPTH_WORDS(4096), .WAIT_CYCLES(0)) dut0 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus0.slave)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // Model memory: index 1 tracks the WAIT_CYCLES=2 instance, index 0 the zero-wait one.
  bit [31:0] mdl [2][4096];

  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    bit          exp_err;
  } vec_t;

  vec_t vecs[12];

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  task automatic drive(bit sel, bit v, bit we, logic [31:0] a, logic [3:0] be, logic [31:0] wd);
    if (sel) begin
      bus2.req_valid = v; bus2.req_we = we; bus2.req_addr = a;
      bus2.req_be = be; bus2.req_wdata = wd; bus2.req_pc4 = 32'h100 + a;
    end else begin
      bus0.req_valid = v; bus0.req_we = we; bus0.req_addr = a;
      bus0.req_be = be; bus0.req_wdata = wd; bus0.req_pc4 = 32'h100 + a;
    end
  endtask

  function automatic logic get_ready(bit sel); return sel ? bus2.req_ready : bus0.req_ready; endfunction
  function automatic logic get_rv(bit sel);    return sel ? bus2.rsp_valid : bus0.rsp_valid; endfunction
  function automatic logic get_err(bit sel);   return sel ? bus2.rsp_err   : bus0.rsp_err;   endfunction
  function automatic logic get_busy(bit sel);  return sel ? bus2.busy      : bus0.busy;      endfunction
  function automatic logic [31:0] get_rd(bit sel);
    return sel ? bus2.rsp_rdata : bus0.rsp_rdata;
  endfunction

  function automatic void model_clear();
    for (int s = 0; s < 2; s++)
      for (int w = 0; w < 4096; w++) mdl[s][w] = 32'd0;
  endfunction

  // Reference behaviour straight from the rules: reject, else mask-merge a write or return the word.
  task automatic model_apply(bit sel, bit we, logic [31:0] a, logic [3:0] be, logic [31:0] wd,
                             output logic [31:0] rd, output bit e);
    logic [31:0] mask;
    logic [11:0] w;
    e = (a[1:0] != 2'b00) || (a[31:2] >= 30'd4096) || (we && be == 4'b0000);
    w = a[13:2];
    mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    rd = 32'd0;
    if (!e) begin
      if (we) mdl[sel][w] = (mdl[sel][w] & ~mask) | (wd & mask);
      else    rd = mdl[sel][w];
    end
  endtask

  task automatic xact(bit sel, bit we, logic [31:0] a, logic [3:0] be, logic [31:0] wd,
                      string tag, output logic [31:0] rd, output logic e,
                      output logic [31:0] mrd, output bit me);
    int  budget;
    bit  got;
    int  lat;
    budget = 0;
    while (!get_ready(sel) && budget < 50) begin
      @(posedge clk); #1;
      budget++;
    end
    chk({tag, " ready"}, 32'(get_ready(sel)), 32'd1);
    model_apply(sel, we, a, be, wd, mrd, me);
    drive(sel, 1'b1, we, a, be, wd);
    @(posedge clk); #1;
    drive(sel, 1'b0, 1'b0, 32'd0, 4'd0, 32'd0);
    got = 1'b0; lat = 0; rd = 32'd0; e = 1'b0;
    for (int c = 1; c <= 300; c++) begin
      chk({tag, " busy"}, 32'(get_busy(sel)), 32'd1);
      if (get_rv(sel)) begin
        got = 1'b1; lat = c; rd = get_rd(sel); e = get_err(sel);
        break;
      end
      @(posedge clk); #1;
    end
    chk({tag, " rsp seen"}, 32'(got), 32'd1);
    if (got) begin
      chk({tag, " latency"}, 32'(lat), sel ? 32'd3 : 32'd1);
      @(posedge clk); #1;
      chk({tag, " pulse end"}, 32'(get_rv(sel)), 32'd0);
      chk({tag, " ready after"}, 32'(get_ready(sel)), 32'd1);
    end
  endtask

  initial begin
    logic [31:0] rd, mrd;
    logic        e;
    bit          me;

    vecs[0]  = '{1'b1, 32'h0000_0010, 4'b1111, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0};
    vecs[1]  = '{1'b0, 32'h0000_0010, 4'b0000, 32'h0000_0000, 32'hDEAD_BEEF, 1'b0};
    vecs[2]  = '{1'b1, 32'h0000_0010, 4'b0010, 32'h0000_AA00, 32'h0000_0000, 1'b0};
    vecs[3]  = '{1'b0, 32'h0000_0010, 4'b1111, 32'h0000_0000, 32'hDEAD_AAEF, 1'b0};
    vecs[4]  = '{1'b0, 32'h0000_0012, 4'b1111, 32'h0000_0000, 32'h0000_0000, 1'b1};
    vecs[5]  = '{1'b1, 32'h0000_4000, 4'b1111, 32'h1234_5678, 32'h0000_0000, 1'b1};
    vecs[6]  = '{1'b1, 32'h0000_0010, 4'b0000, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1};
    vecs[7]  = '{1'b0, 32'h0000_0010, 4'b0000, 32'h0000_0000, 32'hDEAD_AAEF, 1'b0};
    vecs[8]  = '{1'b1, 32'h0000_3FFC, 4'b1100, 32'hA5A5_5A5A, 32'h0000_0000, 1'b0};
    vecs[9]  = '{1'b0, 32'h0000_3FFC, 4'b0001, 32'h0000_0000, 32'hA5A5_0000, 1'b0};
    vecs[10] = '{1'b0, 32'h0000_4000, 4'b1111, 32'h0000_0000, 32'h0000_0000, 1'b1};
    vecs[11] = '{1'b0, 32'hFFFF_FFF0, 4'b1111, 32'h0000_0000, 32'h0000_0000, 1'b1};

    model_clear();
    drive(1'b0, 1'b0, 1'b0, 32'd0, 4'd0, 32'd0);
    drive(1'b1, 1'b0, 1'b0, 32'd0, 4'd0, 32'd0);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    for (int s = 0; s < 2; s++) begin
      chk("reset ready", 32'(get_ready(s[0])), 32'd1);
      chk("reset busy", 32'(get_busy(s[0])), 32'd0);
      chk("reset rsp_valid", 32'(get_rv(s[0])), 32'd0);
      chk("reset rdata", get_rd(s[0]), 32'd0);
      chk("reset err", 32'(get_err(s[0])), 32'd0);
    end
    reset = 1'b0;
    @(posedge clk); #1;

    // Directed vectors on the two-wait-state instance.
    for (int i = 0; i < 12; i++) begin
      xact(1'b1, vecs[i].we, vecs[i].addr, vecs[i].be, vecs[i].wdata, $sformatf("vec%0d", i),
           rd, e, mrd, me);
      chk($sformatf("vec%0d rdata", i), rd, vecs[i].exp_rd);
      chk($sformatf("vec%0d err", i), 32'(e), 32'(vecs[i].exp_err));
    end

    // Reset while a write is waiting: it must vanish without a response.
    drive(1'b1, 1'b1, 1'b1, 32'h0000_0010, 4'b1111, 32'h1111_1111);
    @(posedge clk); #1;
    drive(1'b1, 1'b0, 1'b0, 32'd0, 4'd0, 32'd0);
    chk("midwait busy", 32'(bus2.busy), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("async reset ready", 32'(bus2.req_ready), 32'd1);
    chk("async reset busy", 32'(bus2.busy), 32'd0);
    chk("async reset rsp_valid", 32'(bus2.rsp_valid), 32'd0);
    model_clear();
    #2 reset = 1'b0;
    @(posedge clk); #1;
    for (int k = 0; k < 6; k++) begin
      chk("no rsp after reset", 32'(bus2.rsp_valid), 32'd0);
      @(posedge clk); #1;
    end
    xact(1'b1, 1'b0, 32'h0000_0010, 4'b1111, 32'd0, "post-reset read", rd, e, mrd, me);
    chk("post-reset rdata", rd, 32'd0);
    chk("post-reset err", 32'(e), 32'd0);

    // Randomised traffic on both instances against the model.
    for (int i = 0; i < 80; i++) begin
      bit          sel;
      bit          we;
      logic [31:0] a;
      logic [3:0]  be;
      logic [31:0] wd;
      int          r;
      sel = 1'($urandom_range(0, 1));
      we  = 1'($urandom_range(0, 1));
      be  = 4'($urandom_range(0, 15));
      wd  = $urandom;
      r   = int'($urandom_range(0, 9));
      if (r <= 6)      a = {18'd0, 10'($urandom_range(0, 15)), 2'b00};
      else if (r == 7) a = {18'd0, 10'($urandom_range(1020, 1023)), 4'b0000} + 32'h3000;
      else if (r == 8) a = {28'd0, 2'($urandom_range(0, 3)), 2'($urandom_range(1, 3))};
      else             a = $urandom | 32'h0000_4000;
      xact(sel, we, a, be, wd, $sformatf("rnd%0d", i), rd, e, mrd, me);
      chk($sformatf("rnd%0d rdata", i), rd, mrd);
      chk($sformatf("rnd%0d err", i), 32'(e), 32'(me));
    end

    // Zero wait states, request held high: ready alternates and each response follows acceptance.
    xact(1'b0, 1'b1, 32'h0000_0010, 4'b1111, 32'hCAFE_F00D, "w0 write", rd, e, mrd, me);
    chk("w0 write err", 32'(e), 32'd0);
    drive(1'b0, 1'b1, 1'b0, 32'h0000_0010, 4'b1111, 32'd0);
    for (int k = 0; k < 7; k++) begin
      if (k == 5) drive(1'b0, 1'b0, 1'b0, 32'd0, 4'd0, 32'd0);
      chk($sformatf("w0 ready[%0d]", k), 32'(bus0.req_ready), (k % 2 == 0) ? 32'd1 : 32'd0);
      chk($sformatf("w0 rsp_valid[%0d]", k), 32'(bus0.rsp_valid),
          (k % 2 == 1) ? 32'd1 : 32'd0);
      if (k % 2 == 1) chk($sformatf("w0 rdata[%0d]", k), bus0.rsp_rdata, 32'hCAFE_F00D);
      @(posedge clk); #1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
